my_func_sweep_ctrl: RTL and testbench

Sequencing controller for the 4-input `my_func` comparison datapath. On command, it drives the shared input vector `x` through all 16 codes. After a programmable settle time it samples the outputs of all parallel realizations and checks each one against the reference realization. It reports a per-realization mismatch mask, a failure count, the first failing code, the captured reference truth table, and a pass flag, replacing the manual display-based comparison with an in-fabric self-check.

---
 rtl/my_func_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_my_func_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_func_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// my_func_sweep_ctrl
//
// Purpose:
//   Self-check sequencer for the 4-input my_func comparison datapath. On a
//   start request it walks the shared input vector x_out through all 16 codes,
//   waits SETTLE cycles per code, samples every realization output and compares
//   each one against the reference realization (y_in[N_IMPL-1]). It reports a
//   sticky per-realization mismatch mask, the number of failing codes, the
//   first failing code, the captured reference truth table and a pass flag.
//
// Handshake:
//   start is a level request sampled only in IDLE; abort is a cancel sampled
//   only in SWEEP and wins over a sample on the same edge. busy is high for
//   the whole sweep, done is a one-cycle pulse on normal completion only.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   sweep request (IDLE only)
//   abort        in   sweep cancel (SWEEP only)
//   x_out        out  [3:0] vector driven to every realization
//   y_in         in   [N_IMPL-1:0] realization outputs, MSB is the reference
//   busy         out  sweep in progress
//   done         out  one-cycle completion pulse
//   pass         out  last completed sweep had no mismatch
//   mism_mask    out  [N_IMPL-1:0] sticky disagreement flags (MSB always 0)
//   fail_count   out  [4:0] number of codes with any disagreement
//   first_fail_x out  [3:0] first failing code (valid when fail_count != 0)
//   tt           out  [15:0] reference truth table, tt[i] = ref output at x=i
// -----------------------------------------------------------------------------
module my_func_sweep_ctrl #(
    parameter int N_IMPL = 7,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        x_out,
    input  logic [N_IMPL-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IMPL-1:0] mism_mask,
    output logic [4:0]        fail_count,
    output logic [3:0]        first_fail_x,
    output logic [15:0]       tt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // The counter counts down to zero; loading SETTLE-1 puts the sample edge
    // exactly SETTLE edges after x_out last changed.
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IMPL-1:0] mism_q, mism_d;
    logic [4:0]        fail_q, fail_d;
    logic [3:0]        first_q, first_d;
    logic [15:0]       tt_q, tt_d;

    logic [N_IMPL-1:0] diff;
    logic              y_ref;

    assign y_ref = y_in[N_IMPL-1];
    // Reference bit XOR itself is always 0, so mism_mask MSB never sets.
    assign diff  = y_in ^ {N_IMPL{y_ref}};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mism_d  = mism_q;
        fail_d  = fail_q;
        first_d = first_q;
        tt_d    = tt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = 4'd0;
                    cnt_d   = SETTLE_RELOAD;
                    pass_d  = 1'b0;
                    mism_d  = '0;
                    fail_d  = 5'd0;
                    first_d = 4'd0;
                    tt_d    = 16'd0;
                end
            end
            SWEEP: begin
                if (abort) begin
                    // Partial results are kept; the vector on this edge is dropped.
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end else if (cnt_q == 8'd0) begin
                    mism_d      = mism_q | diff;
                    tt_d[idx_q] = y_ref;
                    if (diff != '0) begin
                        fail_d = fail_q + 5'd1;
                        if (fail_q == 5'd0) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                        pass_d  = ((mism_q | diff) == '0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = SETTLE_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mism_q  <= '0;
            fail_q  <= 5'd0;
            first_q <= 4'd0;
            tt_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            tt_q    <= tt_d;
        end
    end

    assign x_out        = idx_q;
    assign busy         = (state_q == SWEEP);
    assign done         = done_q;
    assign pass         = pass_q;
    assign mism_mask    = mism_q;
    assign fail_count   = fail_q;
    assign first_fail_x = first_q;
    assign tt           = tt_q;

endmodule

// File: tb/tb_my_func_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_my_func_sweep_ctrl
//
// Directed bench for my_func_sweep_ctrl. Two instances share clock and reset:
// u_dut2 (SETTLE=2) covers pass/fail/abort/reset sweeps, u_dut1 (SETTLE=1)
// covers back-to-back sweeps with start held high. Realization outputs are
// modelled from a reference truth table plus optional injected faults.
// -----------------------------------------------------------------------------
module tb_my_func_sweep_ctrl;

    localparam int N = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // SETTLE = 2 instance
    logic         start2 = 1'b0;
    logic         abort2 = 1'b0;
    logic [3:0]   x2;
    logic [N-1:0] y2;
    logic         busy2, done2, pass2;
    logic [N-1:0] mism2;
    logic [4:0]   fc2;
    logic [3:0]   ff2;
    logic [15:0]  tt2;

    // SETTLE = 1 instance
    logic         start1 = 1'b0;
    logic         abort1 = 1'b0;
    logic [3:0]   x1;
    logic [N-1:0] y1;
    logic         busy1, done1, pass1;
    logic [N-1:0] mism1;
    logic [4:0]   fc1;
    logic [3:0]   ff1;
    logic [15:0]  tt1;

    // Realization model controls
    logic [15:0] ref2   = 16'h0000;
    logic        stuck2 = 1'b0;   // y2[2] stuck at 1
    logic        inv2   = 1'b0;   // y2[0] inverted at x=9 and x=12
    logic [15:0] ref1   = 16'h6996;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        y2 = {N{ref2[x2]}};
        if (stuck2) y2[2] = 1'b1;
        if (inv2 && (x2 == 4'd9 || x2 == 4'd12)) y2[0] = ~y2[0];
    end

    assign y1 = {N{ref1[x1]}};

    my_func_sweep_ctrl #(.N_IMPL(N), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .x_out(x2), .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
        .mism_mask(mism2), .fail_count(fc2), .first_fail_x(ff2), .tt(tt2)
    );

    my_func_sweep_ctrl #(.N_IMPL(N), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .x_out(x1), .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
        .mism_mask(mism1), .fail_count(fc1), .first_fail_x(ff1), .tt(tt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sweep2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
    endtask

    // Cycles from acceptance until done2 is seen, bounded.
    task automatic run_to_done2(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (done2) break;
        end
    endtask

    int cyc;
    int done_seen;
    logic [3:0] exp_x;
    logic       exp_done;

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy",  32'(busy2), 32'h0);
        check("rst_done",  32'(done2), 32'h0);
        check("rst_pass",  32'(pass2), 32'h0);
        check("rst_x",     32'(x2),    32'h0);
        check("rst_mism",  32'(mism2), 32'h0);
        check("rst_fc",    32'(fc2),   32'h0);
        check("rst_tt",    32'(tt2),   32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- clean sweep ----------------
        ref2 = 16'hB2E4;
        start_sweep2();
        check("t1_busy_start", 32'(busy2), 32'h1);
        check("t1_x_start",    32'(x2),    32'h0);
        run_to_done2(cyc);
        check("t1_done_latency", 32'(cyc), 32'd32);
        check("t1_busy_end",     32'(busy2), 32'h0);
        check("t1_pass",         32'(pass2), 32'h1);
        check("t1_mism",         32'(mism2), 32'h0);
        check("t1_fc",           32'(fc2),   32'h0);
        check("t1_tt",           32'(tt2),   32'hB2E4);
        tick();
        check("t1_done_one_cycle", 32'(done2), 32'h0);
        check("t1_pass_hold",      32'(pass2), 32'h1);

        // ---------------- y[2] stuck at 1 ----------------
        ref2   = 16'hFACA;
        stuck2 = 1'b1;
        start_sweep2();
        run_to_done2(cyc);
        check("t2_done_latency", 32'(cyc),  32'd32);
        check("t2_mism",         32'(mism2), 32'h04);
        check("t2_fc",           32'(fc2),   32'd6);
        check("t2_ff",           32'(ff2),   32'd0);
        check("t2_pass",         32'(pass2), 32'h0);
        check("t2_tt",           32'(tt2),   32'hFACA);

        // ---------------- y[0] inverted at 9 and 12 ----------------
        ref2   = 16'hB2E4;
        stuck2 = 1'b0;
        inv2   = 1'b1;
        start_sweep2();
        run_to_done2(cyc);
        check("t3_done_latency", 32'(cyc),  32'd32);
        check("t3_fc",           32'(fc2),   32'd2);
        check("t3_ff",           32'(ff2),   32'd9);
        check("t3_mism",         32'(mism2), 32'h01);
        check("t3_pass",         32'(pass2), 32'h0);
        check("t3_tt",           32'(tt2),   32'hB2E4);

        // ---------------- ignored start, then abort ----------------
        inv2 = 1'b0;
        ref2 = 16'h00FF;
        start_sweep2();                 // now E0+1ns
        repeat (3) tick();              // E0+3
        start2 = 1'b1;
        tick();                         // E0+4: must be ignored
        start2 = 1'b0;
        check("t4_restart_ignored_x", 32'(x2),    32'd2);
        check("t4_busy_mid",          32'(busy2), 32'h1);
        repeat (5) tick();              // E0+9
        check("t4_x_before_abort",    32'(x2),    32'd4);
        abort2 = 1'b1;
        tick();                         // E0+10: sample edge of vector 4
        abort2 = 1'b0;
        check("t4_busy_abort", 32'(busy2), 32'h0);
        check("t4_done_abort", 32'(done2), 32'h0);
        check("t4_pass_abort", 32'(pass2), 32'h0);
        check("t4_x_abort",    32'(x2),    32'h0);
        check("t4_tt_partial", 32'(tt2),   32'h000F);
        check("t4_fc_abort",   32'(fc2),   32'h0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done2) done_seen++;
        end
        check("t4_no_done", 32'(done_seen), 32'h0);
        check("t4_idle_busy", 32'(busy2), 32'h0);

        // ---------------- async reset mid-sweep ----------------
        ref2   = 16'hFACA;
        stuck2 = 1'b1;
        start_sweep2();
        repeat (14) tick();
        check("t5_x_pre_reset",  32'(x2),  32'd7);
        check("t5_fc_pre_reset", 32'(fc2), 32'd4);
        #2 rst_n = 1'b0;
        #1;                             // still well before the next rising edge
        check("t5_rst_busy", 32'(busy2), 32'h0);
        check("t5_rst_done", 32'(done2), 32'h0);
        check("t5_rst_pass", 32'(pass2), 32'h0);
        check("t5_rst_x",    32'(x2),    32'h0);
        check("t5_rst_mism", 32'(mism2), 32'h0);
        check("t5_rst_fc",   32'(fc2),   32'h0);
        check("t5_rst_ff",   32'(ff2),   32'h0);
        check("t5_rst_tt",   32'(tt2),   32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_sweep2();
        run_to_done2(cyc);
        check("t5_full_latency", 32'(cyc),  32'd32);
        check("t5_fc",           32'(fc2),   32'd6);
        check("t5_mism",         32'(mism2), 32'h04);
        check("t5_tt",           32'(tt2),   32'hFACA);
        stuck2 = 1'b0;

        // ---------------- back-to-back, SETTLE = 1 ----------------
        start1 = 1'b1;
        for (int j = 0; j < 34; j++) begin
            tick();                     // after edge E0+j
            if (j <= 15)      exp_x = 4'(j);
            else if (j == 16) exp_x = 4'd0;
            else if (j <= 32) exp_x = 4'(j - 17);
            else              exp_x = 4'd0;
            exp_done = (j == 16) || (j == 33);
            check($sformatf("t6_x_%0d", j),    32'(x1),    32'(exp_x));
            check($sformatf("t6_done_%0d", j), 32'(done1), 32'(exp_done));
        end
        start1 = 1'b0;
        check("t6_pass", 32'(pass1), 32'h1);
        check("t6_tt",   32'(tt1),   32'h6996);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
